// File: rtl/oddr_serializer.sv
// Purpose: parallel-to-DDR gearbox feeding an ODDR's d1/d2 pins two bits per clock.
// Latency: word accepted at edge E (block idle) shows pair0 after E+1, last pair after E+WIDTH/2.
// Backpressure: one-word hold register; s_ready drops only while hold is full and not being drained.
module oddr_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             d1,
  output logic             d2,
  output logic             busy,
  output logic             underrun
);

  localparam int BEATS = WIDTH / 2;
  localparam int RW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Reject widths that cannot be split into whole bit pairs.
  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("oddr_serializer: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             d1_q, d1_d;
  logic             d2_q, d2_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;

  logic load_now;
  logic xfer;

  // The pair that goes out next always sits at the same end of the word.
  function automatic logic [1:0] head_pair(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return {w[0], w[1]};
    else           return {w[WIDTH-1], w[WIDTH-2]};
  endfunction

  // Drop the pair just emitted so the following pair moves to the head.
  function automatic logic [WIDTH-1:0] rest(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return w >> 2;
    else           return w << 2;
  endfunction

  // Hold drains into the shifter when nothing is on the wire or the last pair is going out.
  assign load_now = hold_v_q && ((state_q == ST_IDLE) || (rem_q == '0));
  assign s_ready  = !hold_v_q || load_now;
  assign xfer     = s_valid && s_ready;

  // Next-state: pick the output pair, advance the beat counter, manage the hold slot.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    shift_d    = shift_q;
    rem_d      = rem_q;
    d1_d       = IDLE_VAL;
    d2_d       = IDLE_VAL;
    underrun_d = 1'b0;

    if (load_now) begin
      {d1_d, d2_d} = head_pair(hold_q);
      shift_d      = rest(hold_q);
      rem_d        = RW'(BEATS - 1);
      state_d      = ST_SHIFT;
      hold_v_d     = 1'b0;
    end else if ((state_q == ST_SHIFT) && (rem_q != '0)) begin
      {d1_d, d2_d} = head_pair(shift_q);
      shift_d      = rest(shift_q);
      rem_d        = rem_q - RW'(1);
    end else if (state_q == ST_SHIFT) begin
      // Last pair already out and nothing queued behind it: stream ran dry.
      state_d    = ST_IDLE;
      underrun_d = 1'b1;
    end

    if (xfer) begin
      hold_d   = s_data;
      hold_v_d = 1'b1;
    end

    busy_d = (state_d == ST_SHIFT) || hold_v_d;
  end

  // State and output registers; reset discards any word in flight or held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      shift_q    <= '0;
      rem_q      <= '0;
      d1_q       <= IDLE_VAL;
      d2_q       <= IDLE_VAL;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign d1       = d1_q;
  assign d2       = d2_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule
